// File: rtl/vga_pkg.sv
// Shared VGA timing constants and fetcher state encoding.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_TOTAL   = 10'd800;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    VBLANK  = 2'd1,
    SWAPPED = 2'd2,
    SCAN    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Lookahead coordinate, window test and multiplier-free frame-buffer
// address generation (column counter plus row base accumulator).
module window_addr_gen
  import vga_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int X0     = 192,
  parameter int Y0     = 112,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_en,
  input  logic              rd_allow,
  input  logic              bank,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  output logic [9:0]        tgt_h,
  output logic [9:0]        tgt_v,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en
);

  localparam int OW = ADDR_W - 1;
  localparam logic [10:0]   X_LO     = 11'(X0);
  localparam logic [10:0]   X_HI     = 11'(X0 + IMG_W);
  localparam logic [10:0]   Y_LO     = 11'(Y0);
  localparam logic [10:0]   Y_HI     = 11'(Y0 + IMG_H);
  localparam logic [OW-1:0] COL_LAST = OW'(IMG_W - 1);
  localparam logic [OW-1:0] ROW_STEP = OW'(IMG_W);

  logic [OW-1:0]     col_q, col_d, row_base_q, row_base_d;
  logic [OW-1:0]     base, col;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              in_win, at_origin;

  // Pixel that will be on screen when the fetched sample is presented.
  always_comb begin
    tgt_h = h_count + 10'd1;
    tgt_v = v_count;
    if (h_count == H_TOTAL - 10'd1) begin
      tgt_h = '0;
      tgt_v = (v_count == V_TOTAL - 10'd1) ? '0 : v_count + 10'd1;
    end
  end

  assign in_win = ({1'b0, tgt_h} >= X_LO) && ({1'b0, tgt_h} < X_HI) &&
                  ({1'b0, tgt_v} >= Y_LO) && ({1'b0, tgt_v} < Y_HI) &&
                  (tgt_h < H_VISIBLE) && (tgt_v < V_VISIBLE);
  assign at_origin = ({1'b0, tgt_h} == X_LO) && ({1'b0, tgt_v} == Y_LO);

  // Issue one read per in-window target; the window origin re-anchors the
  // counters so any earlier disturbance never leaks into the next frame.
  always_comb begin
    col_d       = col_q;
    row_base_d  = row_base_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    base        = at_origin ? '0 : row_base_q;
    col         = at_origin ? '0 : col_q;
    if (pixel_en && rd_allow && in_win) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = {bank, base + col};
      if (col == COL_LAST) begin
        col_d      = '0;
        row_base_d = base + ROW_STEP;
      end else begin
        col_d      = col + OW'(1);
        row_base_d = base;
      end
    end
  end

  // Counter and read-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_base_q  <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_base_q  <= row_base_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;

endmodule

// File: rtl/frame_pixel_fetcher.sv
// VGA pixel source: fetches a grayscale image from a double-banked RAM
// with one pixel of lookahead and swaps banks only during vertical blank.
module frame_pixel_fetcher
  import vga_pkg::*;
#(
  parameter int         IMG_W   = 256,
  parameter int         IMG_H   = 256,
  parameter int         X0      = 192,
  parameter int         Y0      = 112,
  parameter int         RD_LAT  = 2,
  parameter logic [7:0] BG_GRAY = 8'h00,
  parameter int         ADDR_W  = $clog2(2 * IMG_W * IMG_H)
) (
  input  logic              FPGA_Clock,
  input  logic              reset,
  input  logic              pixel_en,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        R_IN,
  output logic [7:0]        G_IN,
  output logic [7:0]        B_IN,
  output logic              pix_valid,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              disp_bank
);

  fetch_state_t state_q, state_d;
  logic       bank_q, bank_d, ack_q, ack_d, seen_q, seen_d;
  logic [9:0] tgt_h, tgt_v;
  logic       tgt_origin, vb_edge, swap_ok, rd_allow, cap;
  logic [7:0] rgb_q, rgb_d, hold_q, hold_d;
  logic       pv_q, pv_d, hold_vld_q, hold_vld_d;

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X0    (X0),
    .Y0    (Y0),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk      (FPGA_Clock),
    .rst      (reset),
    .pixel_en (pixel_en),
    .rd_allow (rd_allow),
    .bank     (bank_q),
    .h_count  (h_count),
    .v_count  (v_count),
    .tgt_h    (tgt_h),
    .tgt_v    (tgt_v),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en)
  );

  assign tgt_origin = (tgt_h == '0) && (tgt_v == '0);
  assign vb_edge    = (v_count == V_VISIBLE) && (h_count == '0);
  // seen_q blocks a second swap for a request that has not yet dropped.
  assign swap_ok    = swap_req && !seen_q;
  // The frame's first read happens on the same strobe that enters SCAN.
  assign rd_allow   = (state_q == SCAN) ||
                      (((state_q == VBLANK) || (state_q == SWAPPED)) && tgt_origin);

  // Frame sequencing and bank-swap handshake; all moves on pixel_en only.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    seen_d  = seen_q;
    if (pixel_en) begin
      if (!swap_req) seen_d = 1'b0;
      case (state_q)
        SYNC: if (vb_edge) state_d = VBLANK;
        SCAN: if (vb_edge) begin
          state_d = VBLANK;
          if (swap_ok) begin
            bank_d  = ~bank_q;
            ack_d   = 1'b1;
            seen_d  = 1'b1;
            state_d = SWAPPED;
          end
        end
        VBLANK: begin
          if (tgt_origin) begin
            state_d = SCAN;
          end else if (swap_ok) begin
            bank_d  = ~bank_q;
            ack_d   = 1'b1;
            seen_d  = 1'b1;
            state_d = SWAPPED;
          end
        end
        SWAPPED: if (tgt_origin) state_d = SCAN;
        default: state_d = SYNC;
      endcase
    end
  end

  // FSM and handshake registers.
  always_ff @(posedge FPGA_Clock or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      seen_q  <= seen_d;
    end
  end

  // Capture strobe: mem_rdata is valid RD_LAT clocks after the issuing edge,
  // so the last cycle before capture is RD_LAT-1 cycles after mem_rd_en.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign cap = mem_rd_en;
    end else begin : g_lat2
      logic vld_q;
      // Delay the read strobe by one cycle for a registered RAM output.
      always_ff @(posedge FPGA_Clock or posedge reset) begin
        if (reset) vld_q <= 1'b0;
        else       vld_q <= mem_rd_en;
      end
      assign cap = vld_q;
    end
  endgenerate

  // Hold the returned sample until the next pixel strobe, bypassing the
  // hold register when the sample arrives on the strobe itself.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    rgb_d      = rgb_q;
    pv_d       = pv_q;
    if (pixel_en) begin
      rgb_d      = cap ? mem_rdata : (hold_vld_q ? hold_q : BG_GRAY);
      pv_d       = cap | hold_vld_q;
      hold_vld_d = 1'b0;
    end else if (cap) begin
      hold_d     = mem_rdata;
      hold_vld_d = 1'b1;
    end
  end

  // Output and hold registers.
  always_ff @(posedge FPGA_Clock or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      rgb_q      <= BG_GRAY;
      pv_q       <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rgb_q      <= rgb_d;
      pv_q       <= pv_d;
    end
  end

  assign R_IN      = rgb_q;
  assign G_IN      = rgb_q;
  assign B_IN      = rgb_q;
  assign pix_valid = pv_q;
  assign swap_ack  = ack_q;
  assign disp_bank = bank_q;

endmodule

// File: tb/tb_frame_pixel_fetcher.sv
// Directed bench: a default-size instance, a small-window instance for
// frame/bank checks, and two origin-placed instances for RD_LAT 1 and 2.
module tb_frame_pixel_fetcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_en;
  logic [9:0] h_count, v_count;
  logic       swap_req;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  // default instance: 256x256 at (192,112), RD_LAT=2
  logic [16:0] def_addr;
  logic        def_rd, def_pv, def_ack, def_bank;
  logic [7:0]  def_rdata, def_r, def_g, def_b;
  // small instance: 8x4 at (192,112), RD_LAT=2
  logic [5:0]  sm_addr;
  logic        sm_rd, sm_pv, sm_ack, sm_bank;
  logic [7:0]  sm_rdata, sm_r, sm_g, sm_b;
  // origin instances: 8x4 at (0,0), RD_LAT=1 and 2
  logic [5:0]  l1_addr, l2_addr;
  logic        l1_rd, l1_pv, l1_ack, l1_bank, l2_rd, l2_pv, l2_ack, l2_bank;
  logic [7:0]  l1_rdata, l1_r, l1_g, l1_b, l2_rdata, l2_r, l2_g, l2_b;

  // RAM models: RAM[a] = a[7:0]
  always @(posedge clk) def_rdata <= def_addr[7:0];
  always @(posedge clk) sm_rdata  <= 8'(sm_addr);
  always @(posedge clk) l2_rdata  <= 8'(l2_addr);
  assign l1_rdata = 8'(l1_addr);

  frame_pixel_fetcher u_def (
    .FPGA_Clock(clk), .reset(reset), .pixel_en(pixel_en), .h_count(h_count), .v_count(v_count),
    .mem_addr(def_addr), .mem_rd_en(def_rd), .mem_rdata(def_rdata),
    .R_IN(def_r), .G_IN(def_g), .B_IN(def_b), .pix_valid(def_pv),
    .swap_req(swap_req), .swap_ack(def_ack), .disp_bank(def_bank));

  frame_pixel_fetcher #(.IMG_W(8), .IMG_H(4), .X0(192), .Y0(112), .RD_LAT(2)) u_sm (
    .FPGA_Clock(clk), .reset(reset), .pixel_en(pixel_en), .h_count(h_count), .v_count(v_count),
    .mem_addr(sm_addr), .mem_rd_en(sm_rd), .mem_rdata(sm_rdata),
    .R_IN(sm_r), .G_IN(sm_g), .B_IN(sm_b), .pix_valid(sm_pv),
    .swap_req(swap_req), .swap_ack(sm_ack), .disp_bank(sm_bank));

  frame_pixel_fetcher #(.IMG_W(8), .IMG_H(4), .X0(0), .Y0(0), .RD_LAT(1)) u_l1 (
    .FPGA_Clock(clk), .reset(reset), .pixel_en(pixel_en), .h_count(h_count), .v_count(v_count),
    .mem_addr(l1_addr), .mem_rd_en(l1_rd), .mem_rdata(l1_rdata),
    .R_IN(l1_r), .G_IN(l1_g), .B_IN(l1_b), .pix_valid(l1_pv),
    .swap_req(swap_req), .swap_ack(l1_ack), .disp_bank(l1_bank));

  frame_pixel_fetcher #(.IMG_W(8), .IMG_H(4), .X0(0), .Y0(0), .RD_LAT(2)) u_l2 (
    .FPGA_Clock(clk), .reset(reset), .pixel_en(pixel_en), .h_count(h_count), .v_count(v_count),
    .mem_addr(l2_addr), .mem_rd_en(l2_rd), .mem_rdata(l2_rdata),
    .R_IN(l2_r), .G_IN(l2_g), .B_IN(l2_b), .pix_valid(l2_pv),
    .swap_req(swap_req), .swap_ack(l2_ack), .disp_bank(l2_bank));

  // snapshots of one-cycle strobes taken in the cycle after each pixel_en
  logic        def_rd_s, sm_rd_s, sm_ack_s, l1_rd_s, l2_rd_s;
  logic [16:0] def_addr_s;
  logic [5:0]  sm_addr_s, l1_addr_s, l2_addr_s;

  // one pixel period: strobe, then idle clock; returns 1 ns after 2nd edge
  task automatic pix(input int h, input int v);
    h_count  = 10'(h);
    v_count  = 10'(v);
    pixel_en = 1'b1;
    @(posedge clk); #1;
    def_rd_s = def_rd; def_addr_s = def_addr;
    sm_rd_s  = sm_rd;  sm_addr_s  = sm_addr; sm_ack_s = sm_ack;
    l1_rd_s  = l1_rd;  l1_addr_s  = l1_addr;
    l2_rd_s  = l2_rd;  l2_addr_s  = l2_addr;
    pixel_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    pixel_en = 1'b0; swap_req = 1'b0; h_count = '0; v_count = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (def_r !== 8'h00 || def_g !== 8'h00 || def_b !== 8'h00) begin n_bad++;
      $display("FAIL reset_rgb got %h/%h/%h want 00", def_r, def_g, def_b); end
    n_cmp++; if (def_pv !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", def_pv); end
    n_cmp++; if (def_rd !== 1'b0 || def_addr !== 17'd0) begin n_bad++;
      $display("FAIL reset_mem got rd=%b addr=%h want 0/0", def_rd, def_addr); end
    n_cmp++; if (def_ack !== 1'b0 || def_bank !== 1'b0) begin n_bad++;
      $display("FAIL reset_bank got ack=%b bank=%b want 0/0", def_ack, def_bank); end
    // SYNC: strobes before the first VBLANK must not read
    pix(191, 112);
    n_cmp++; if (def_rd_s !== 1'b0) begin n_bad++; $display("FAIL sync_no_read got rd=%b want 0", def_rd_s); end
  endtask

  task automatic test_default_window();
    do_reset();
    pix(0, 480);
    pix(799, 524);
    for (int h = 190; h <= 448; h++) begin
      pix(h, 112);
      if (h == 191) begin
        n_cmp++; if (def_r !== 8'h00 || def_pv !== 1'b0) begin n_bad++;
          $display("FAIL left_of_window got %h v=%b want 00 v=0", def_r, def_pv); end
        n_cmp++; if (def_rd_s !== 1'b1 || def_addr_s !== 17'd0) begin n_bad++;
          $display("FAIL first_read got rd=%b addr=%h want 1/00000", def_rd_s, def_addr_s); end
      end
      if (h == 192) begin
        n_cmp++; if (def_r !== 8'h00 || def_g !== 8'h00 || def_b !== 8'h00 || def_pv !== 1'b1) begin n_bad++;
          $display("FAIL pix_192_112 got %h/%h/%h v=%b want 00 v=1", def_r, def_g, def_b, def_pv); end
      end
      if (h == 193) begin
        n_cmp++; if (def_r !== 8'h01 || def_pv !== 1'b1) begin n_bad++;
          $display("FAIL pix_193_112 got %h v=%b want 01 v=1", def_r, def_pv); end
      end
      if (h == 447) begin
        n_cmp++; if (def_r !== 8'hff || def_pv !== 1'b1) begin n_bad++;
          $display("FAIL pix_447_112 got %h v=%b want ff v=1", def_r, def_pv); end
      end
      if (h == 448) begin
        n_cmp++; if (def_r !== 8'h00 || def_pv !== 1'b0) begin n_bad++;
          $display("FAIL right_of_window got %h v=%b want 00 v=0", def_r, def_pv); end
      end
    end
    pix(191, 113);
    n_cmp++; if (def_rd_s !== 1'b1 || def_addr_s !== 17'd256) begin n_bad++;
      $display("FAIL row2_addr got rd=%b addr=%h want 1/00100", def_rd_s, def_addr_s); end
    pix(192, 113);
    n_cmp++; if (def_r !== 8'h00 || def_pv !== 1'b1 || def_addr_s !== 17'd257) begin n_bad++;
      $display("FAIL pix_192_113 got %h v=%b next_addr=%h want 00 v=1 00101", def_r, def_pv, def_addr_s); end
    pix(193, 113);
    n_cmp++; if (def_r !== 8'h01 || def_pv !== 1'b1) begin n_bad++;
      $display("FAIL pix_193_113 got %h v=%b want 01 v=1", def_r, def_pv); end
  endtask

  // vertical blank for the small instance; counts swap_ack pulses
  task automatic sm_vblank(output int ack480, output int nack);
    pix(0, 480);   ack480 = int'(sm_ack_s); nack = ack480;
    pix(1, 480);   nack += int'(sm_ack_s);
    pix(799, 524); nack += int'(sm_ack_s);
  endtask

  // one visible frame for the small instance; returns reads and errors
  task automatic sm_scan(input logic bank, output int nrd, output int err);
    int idx;
    logic exp_rd;
    logic [7:0] exp_px;
    idx = 0; nrd = 0; err = 0;
    for (int v = 112; v <= 115; v++) begin
      for (int h = 191; h <= 200; h++) begin
        pix(h, v);
        exp_rd = (h <= 198);
        nrd += int'(sm_rd_s);
        if (sm_rd_s !== exp_rd) err++;
        if (exp_rd) begin
          if (sm_addr_s !== {bank, 5'(idx)}) err++;
          idx++;
        end
        if (h >= 192 && h <= 199) begin
          exp_px = {2'b00, bank, 5'((v - 112) * 8 + (h - 192))};
          if (sm_r !== exp_px || sm_pv !== 1'b1) err++;
        end else if (sm_pv !== 1'b0) err++;
        if (sm_ack_s !== 1'b0 || sm_bank !== bank) err++;
      end
    end
    pix(700, 200); nrd += int'(sm_rd_s);
    pix(100, 479); nrd += int'(sm_rd_s);
  endtask

  task automatic test_addr_trace();
    int a480, nack, nrd, err;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      sm_vblank(a480, nack);
      sm_scan(1'b0, nrd, err);
      n_cmp++; if (nrd !== 32) begin n_bad++; $display("FAIL trace_count f%0d got %0d want 32", f, nrd); end
      n_cmp++; if (err !== 0) begin n_bad++; $display("FAIL trace_order f%0d got %0d errors want 0", f, err); end
    end
  endtask

  task automatic test_swap_midscan();
    int a480, nack, nrd, err;
    swap_req = 1'b1;
    pix(0, 200);
    pix(0, 300);
    n_cmp++; if (sm_bank !== 1'b0 || sm_ack_s !== 1'b0) begin n_bad++;
      $display("FAIL swap_in_scan got bank=%b ack=%b want 0/0", sm_bank, sm_ack_s); end
    sm_vblank(a480, nack);
    n_cmp++; if (a480 !== 1 || nack !== 1) begin n_bad++;
      $display("FAIL swap_ack_480 got at480=%0d total=%0d want 1/1", a480, nack); end
    n_cmp++; if (sm_bank !== 1'b1) begin n_bad++; $display("FAIL swap_bank got %b want 1", sm_bank); end
    sm_scan(1'b1, nrd, err);
    n_cmp++; if (nrd !== 32 || err !== 0) begin n_bad++;
      $display("FAIL bank1_frame got reads=%0d errors=%0d want 32/0", nrd, err); end
    swap_req = 1'b0;
    pix(0, 300);
  endtask

  task automatic test_swap_held();
    int a480, nack, tot, nrd, err, eacc;
    do_reset();
    swap_req = 1'b1;
    tot = 0; eacc = 0;
    for (int f = 0; f < 3; f++) begin
      sm_vblank(a480, nack);
      tot += nack;
      sm_scan(1'b1, nrd, err);
      eacc += err;
    end
    n_cmp++; if (tot !== 1) begin n_bad++; $display("FAIL held_one_ack got %0d want 1", tot); end
    n_cmp++; if (eacc !== 0 || sm_bank !== 1'b1) begin n_bad++;
      $display("FAIL held_frames got errors=%0d bank=%b want 0/1", eacc, sm_bank); end
    swap_req = 1'b0;
    pix(0, 300);
    swap_req = 1'b1;
    pix(0, 301);
    sm_vblank(a480, nack);
    n_cmp++; if (a480 !== 1 || nack !== 1 || sm_bank !== 1'b0) begin n_bad++;
      $display("FAIL second_swap got at480=%0d total=%0d bank=%b want 1/1/0", a480, nack, sm_bank); end
    swap_req = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int nrd;
    do_reset();
    pix(0, 480);
    pix(799, 524);
    pix(299, 150);
    pix(300, 150);
    n_cmp++; if (def_pv !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got %b want 1", def_pv); end
    reset = 1'b1;
    #1;
    n_cmp++; if (def_r !== 8'h00 || def_pv !== 1'b0 || def_rd !== 1'b0) begin n_bad++;
      $display("FAIL async_reset got %h v=%b rd=%b want 00 v=0 rd=0", def_r, def_pv, def_rd); end
    @(posedge clk); #1 reset = 1'b0;
    nrd = 0;
    for (int h = 301; h <= 305; h++) begin pix(h, 150); nrd += int'(def_rd_s); end
    pix(0, 480);   nrd += int'(def_rd_s);
    pix(799, 524); nrd += int'(def_rd_s);
    pix(190, 112); nrd += int'(def_rd_s);
    n_cmp++; if (nrd !== 0 || def_pv !== 1'b0) begin n_bad++;
      $display("FAIL post_reset_quiet got reads=%0d v=%b want 0/0", nrd, def_pv); end
    pix(191, 112);
    n_cmp++; if (def_rd_s !== 1'b1 || def_addr_s !== 17'd0) begin n_bad++;
      $display("FAIL post_reset_first got rd=%b addr=%h want 1/00000", def_rd_s, def_addr_s); end
  endtask

  task automatic test_origin_latency();
    int e1, e2;
    logic [7:0] exp_px;
    logic exp_v;
    do_reset();
    pix(0, 480);
    pix(799, 524);
    n_cmp++; if (l1_rd_s !== 1'b1 || l1_addr_s !== 6'd0 || l2_rd_s !== 1'b1 || l2_addr_s !== 6'd0) begin n_bad++;
      $display("FAIL origin_read got l1=%b/%h l2=%b/%h want 1/00", l1_rd_s, l1_addr_s, l2_rd_s, l2_addr_s); end
    e1 = 0; e2 = 0;
    for (int h = 0; h <= 8; h++) begin
      pix(h, 0);
      exp_v  = (h < 8);
      exp_px = exp_v ? 8'(h) : 8'h00;
      if (l1_r !== exp_px || l1_pv !== exp_v) e1++;
      if (l2_r !== exp_px || l2_pv !== exp_v) e2++;
      if (h == 0) begin
        n_cmp++; if (l1_r !== 8'h00 || l1_pv !== 1'b1 || l2_r !== 8'h00 || l2_pv !== 1'b1) begin n_bad++;
          $display("FAIL pix_0_0 got l1=%h/%b l2=%h/%b want 00/1", l1_r, l1_pv, l2_r, l2_pv); end
      end
    end
    n_cmp++; if (e1 !== 0) begin n_bad++; $display("FAIL lat1_row0 got %0d errors want 0", e1); end
    n_cmp++; if (e2 !== 0) begin n_bad++; $display("FAIL lat2_row0 got %0d errors want 0", e2); end
    pix(799, 0);
    n_cmp++; if (l1_rd_s !== 1'b1 || l1_addr_s !== 6'd8 || l2_rd_s !== 1'b1 || l2_addr_s !== 6'd8) begin n_bad++;
      $display("FAIL wrap_read got l1=%b/%h l2=%b/%h want 1/08", l1_rd_s, l1_addr_s, l2_rd_s, l2_addr_s); end
    pix(0, 1);
    n_cmp++; if (l1_r !== 8'h08 || l1_pv !== 1'b1 || l2_r !== 8'h08 || l2_pv !== 1'b1 ||
                 l1_g !== 8'h08 || l2_b !== 8'h08) begin n_bad++;
      $display("FAIL pix_0_1 got l1=%h/%b l2=%h/%b want 08/1", l1_r, l1_pv, l2_r, l2_pv); end
    pix(1, 1);
    n_cmp++; if (l1_r !== 8'h09 || l2_r !== 8'h09) begin n_bad++;
      $display("FAIL pix_1_1 got l1=%h l2=%h want 09", l1_r, l2_r); end
  endtask

  initial begin
    reset = 1'b1; pixel_en = 1'b0; swap_req = 1'b0; h_count = '0; v_count = '0;
    test_reset();
    test_default_window();
    test_addr_trace();
    test_swap_midscan();
    test_swap_held();
    test_reset_midframe();
    test_origin_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
